// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Holds the arbiter state encoding, requester ids and an index-width helper.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_BOOT,
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP,
    ARB_ERR
  } arb_state_t;

  localparam int REQ_FETCH   = 0;
  localparam int REQ_ALLOC   = 1;
  localparam int REQ_GC      = 2;
  localparam int NUM_MEM_REQ = 3;

  // Width of an index into n items; never zero so ports stay legal for n == 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: rotates req so ptr lands at bit 0, then takes the
// lowest set bit and maps it back to an absolute requester index.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N = NUM_MEM_REQ
) (
  input  logic [N-1:0]            req,
  input  logic [idx_width(N)-1:0] ptr,
  output logic                    valid,
  output logic [idx_width(N)-1:0] winner
);

  localparam int PW = idx_width(N);

  logic [N-1:0] rot;

  // rot[i] = req[(ptr + i) mod N]; valid because ptr < N.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid  = 1'b1;
        winner = PW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port memory_controller between
// requesters; one transaction at a time, completion signalled by an ack pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = NUM_MEM_REQ,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          err,
  input  logic                          boot_done,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_error
);

  localparam int PW = idx_width(NUM_REQ);
  localparam int CW = idx_width(READ_LATENCY);
  localparam logic [PW-1:0] LAST_ID  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

  arb_state_t            state_reg, state_next;
  logic [PW-1:0]         winner_reg, winner_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

  logic                  pick_valid;
  logic [PW-1:0]         pick_winner;

  rr_picker #(
    .N(NUM_REQ)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .valid (pick_valid),
    .winner(pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_BOOT;
      winner_reg <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
      rdata_reg  <= rdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    rdata_next  = rdata_reg;
    unique case (state_reg)
      ARB_BOOT: begin
        if (boot_done) state_next = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (pick_valid) begin
          winner_next = pick_winner;
          we_next     = req_we[pick_winner];
          addr_next   = req_addr[pick_winner*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_next  = req_wdata[pick_winner*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_next = (pick_winner == LAST_ID) ? '0 : pick_winner + 1'b1;
          state_next  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (we_reg) begin
          state_next = ARB_RESP;
        end else begin
          cnt_next   = CNT_LOAD;
          state_next = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_reg == '0) begin
          rdata_next = mem_rdata;
          state_next = ARB_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      ARB_ERR:  state_next = ARB_ERR;
      default:  state_next = ARB_BOOT;
    endcase
    // A memory fault outranks everything and is only left through rst.
    if (mem_error) state_next = ARB_ERR;
  end

  // A fault reported in the response cycle still swallows the ack.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack[gi] = (state_reg == ARB_RESP) && !mem_error && (winner_reg == PW'(gi));
  end

  assign mem_we    = (state_reg == ARB_ISSUE) && we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;
  assign busy      = (state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT) || (state_reg == ARB_RESP);
  assign err       = (state_reg == ARB_ERR);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port memory_controller between up to NUM_REQ requesters: fetch engine, cons allocator and future GC.
- Arbitrates round-robin, runs one read or write transaction at a time, and returns read data with a one-cycle ack pulse.
- Sits between the core-side requester FSMs and memory_controller.
- Replaces the ad-hoc addr latch inside core.

Parameters:
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 16, memory word width
- NUM_REQ, 3, number of requesters (index 0 = fetch, 1 = alloc, 2 = gc)
- READ_LATENCY, 2, cycles from address presented on mem_addr to valid mem_rdata (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transaction request
- req_we  in  NUM_REQ  per-requester write flag (1 = write, 0 = read)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  out  DATA_WIDTH  read result, valid in the ack cycle
- busy  out  1  transaction in flight (state not IDLE/BOOT/ERR)
- err  out  1  sticky memory error
- boot_done  in  1  from memory_controller; no grants until high
- mem_addr  out  ADDR_WIDTH  to memory_controller addr
- mem_we  out  1  to memory_controller write_enable
- mem_wdata  out  DATA_WIDTH  to memory_controller write_data
- mem_rdata  in  DATA_WIDTH  from memory_controller read_data
- mem_error  in  1  from memory_controller memory_error

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = BOOT
  - ack = 0, rdata = 0, busy = 0, err = 0
  - mem_addr = 0, mem_we = 0, mem_wdata = 0
  - rr_ptr = 0, wait counter = 0
- Reset mid-transaction aborts it; no ack is issued for the aborted transaction.
- States:
  - BOOT: hold until boot_done = 1, then go to IDLE.
  - IDLE: if any req bit is set, pick the winner by round-robin starting at rr_ptr. Latch winner id, we, addr and wdata into internal registers. Set rr_ptr = (winner+1) mod NUM_REQ. Go to ISSUE. No req set: stay in IDLE.
  - ISSUE (1 cycle): mem_addr and mem_wdata are driven from the latched values. mem_we = latched we. Write goes to RESP. Read loads the counter with READ_LATENCY-1 and goes to WAIT.
  - WAIT: mem_addr held and mem_we = 0. Counter decrements each cycle. When the counter is 0, capture mem_rdata into rdata and go to RESP.
  - RESP (1 cycle): ack[winner] = 1, all other ack bits 0. rdata stays stable until the next read capture. Go to IDLE.
  - ERR: err = 1, no grants, ack = 0, mem_we = 0. Exit only by rst.
- mem_we is asserted in the ISSUE cycle only.
- mem_addr holds its last value outside transactions.
- Latency, with req sampled in IDLE at cycle T:
  - write: mem_we at T+1, ack at T+2.
  - read: address presented from T+1, ack at T+2+READ_LATENCY (T+4 at the default).
- Back-to-back: minimum 3 cycles per write, READ_LATENCY+3 per read; the IDLE cycle is always spent.
- Handshake rules:
  - Requester holds req, req_we, req_addr and req_wdata stable from assertion until it sees ack.
  - Requester drops req in the cycle after ack unless it is issuing a new transaction.
  - A req dropped before grant is simply not served.
  - Changes to a non-granted requester's inputs are ignored.
- Fairness: the requester just served has lowest priority next. Every asserted req is granted within NUM_REQ transactions.
- Simultaneous events:
  - Requests arriving during ISSUE/WAIT/RESP wait for IDLE.
  - mem_error in any state except BOOT goes to ERR on the next edge and suppresses the pending ack.
  - mem_error during BOOT is also taken to ERR.
- Out-of-range addresses are passed through unchanged; range checking belongs to memory_controller, which flags them via mem_error.

Decomposition:
- Package lisp gains:
  - arb_state_t enum {ARB_BOOT, ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, ARB_ERR}
  - localparams REQ_FETCH=0, REQ_ALLOC=1, REQ_GC=2, NUM_MEM_REQ=3
- One sub-module, rr_picker (parameter N). Inputs: req[N], ptr. Outputs: valid, winner index. Combinational rotate-and-priority-encode, instantiated once.
- The FSM, registers and wait counter live in mem_arbiter.

Test Plan:
- Boot gating: rst, req=3'b001, boot_done=0 for 10 cycles -> no ack, mem_we=0, busy=0. Raise boot_done -> read granted, ack[0] 4 cycles after the first IDLE sample.
- Single read: memory holds 0x00AB at addr 0x0012, req[0]=1, we=0 -> mem_addr=0x0012 from T+1, ack=3'b001 at T+4 with rdata=0x00AB, a single-cycle pulse.
- Single write: req[1]=1, we=1, addr 0x0020, wdata 0xBEEF -> mem_we=1 only at T+1 with mem_addr=0x0020 and mem_wdata=0xBEEF, ack=3'b010 at T+2. A following read of 0x0020 returns 0xBEEF.
- Round-robin: all three req held continuously from rr_ptr=0 -> grant order 0,1,2,0,1,2. No requester is granted twice before the others.
- Error: mem_error pulsed during WAIT of a read by requester 2 -> no ack[2], err=1 next cycle and sticky. A new req gets no grant. rst clears err and returns to BOOT.
- Reset mid-write: rst asserted in the ISSUE cycle -> next cycle all outputs are at reset values, no ack, state BOOT.
